timer_sequencer: RTL

Avalon-MM write-only master that sequences the 16-bit-register interval timer peripheral on behalf of one host command port. It programs the 32-bit period, starts the timer in continuous mode with interrupt enabled, services each timeout IRQ by clearing status, counts ticks and stops the timer after a requested tick count or on abort. It sits between system control logic and the timer slave, replacing CPU-driven timer servicing.

---
 rtl/timer_seq_pkg.sv | 26 ++
 rtl/timer_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/timer_seq_pkg.sv
// Shared state type, register map and control words for the interval-timer sequencer.
package timer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, WR_PERL, WR_PERH, WR_CTRL, WAIT_IRQ, WR_CLR, CLR_GAP, WR_STOP
  } state_t;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;

  localparam int unsigned ITO   = 0;
  localparam int unsigned CONT  = 1;
  localparam int unsigned START = 2;
  localparam int unsigned STOP  = 3;

  localparam logic [3:0] CTRL_RUN  = 4'((1 << START) | (1 << CONT) | (1 << ITO));
  localparam logic [3:0] CTRL_STOP = 4'(1 << STOP);

  // Timer counts load+1 cycles per timeout; periods below 2 clamp to load 1.
  function automatic logic [31:0] load_of(input logic [31:0] period);
    return (period < 32'd2) ? 32'd1 : period - 32'd1;
  endfunction

endpackage

// File: rtl/timer_sequencer.sv
// Avalon-MM write master that programs, services and stops the interval timer
// for one host command: period setup, per-timeout status clear, tick counting.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_period,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              abort,
  output logic              busy,
  output logic              tick,
  output logic [CNT_W-1:0]  tick_count,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              timer_irq
);

  state_t           state;
  logic [31:0]      load;
  logic [31:0]      load_in;
  logic [CNT_W-1:0] count_tgt;
  logic             abort_pend;
  logic             abort_req;
  logic             count_hit;
  logic             stop_now;

  // All three exits into WR_STOP share one condition so the stop write is coded once.
  always_comb begin
    load_in   = load_of(cmd_period);
    abort_req = abort_pend | abort;
    count_hit = (count_tgt != '0) && (tick_count == count_tgt);
    stop_now  = 1'b0;
    case (state)
      WR_CTRL:  stop_now = abort_req;
      WAIT_IRQ: stop_now = !timer_irq && abort_req;
      CLR_GAP:  stop_now = abort_req || count_hit;
      default:  stop_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      load           <= '0;
      count_tgt      <= '0;
      abort_pend     <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      tick           <= 1'b0;
      done           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      if (state != IDLE && abort) abort_pend <= 1'b1;

      if (stop_now) begin
        state          <= WR_STOP;
        done           <= 1'b1;
        aborted        <= abort_req;
        avm_chipselect <= 1'b1;
        avm_write_n    <= 1'b0;
        avm_address    <= CONTROL;
        avm_writedata  <= DATA_W'(CTRL_STOP);
      end else begin
        case (state)
          IDLE: if (cmd_valid && cmd_ready) begin
            load           <= load_in;
            count_tgt      <= cmd_count;
            tick_count     <= '0;
            aborted        <= 1'b0;
            abort_pend     <= 1'b0;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= WR_PERL;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= PERIODL;
            avm_writedata  <= load_in[DATA_W-1:0];
          end
          WR_PERL: begin
            state          <= WR_PERH;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= PERIODH;
            avm_writedata  <= load[31:16];
          end
          WR_PERH: begin
            state          <= WR_CTRL;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= CONTROL;
            avm_writedata  <= DATA_W'(CTRL_RUN);
          end
          WR_CTRL: state <= WAIT_IRQ;
          WAIT_IRQ: if (timer_irq) begin
            tick           <= 1'b1;
            tick_count     <= tick_count + CNT_W'(1);
            state          <= WR_CLR;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= STATUS;
            avm_writedata  <= '0;
          end
          WR_CLR:  state <= CLR_GAP;
          CLR_GAP: state <= WAIT_IRQ;
          WR_STOP: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
